// File: rtl/cpu_isa_pkg.sv
// ISA constants shared by fetch and decode stages:
// opcode values and instruction field bit positions.
package cpu_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam int OPC_LSB   = 26;
    localparam int RA_LSB    = 21;
    localparam int RB_LSB    = 16;
    localparam int WR1_LSB   = 16;
    localparam int WR2_LSB   = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;
    localparam int ADDR_LSB  = 0;
    localparam int IMM_LSB   = 0;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Push-side handshake between instruction fetch and the queue.
// Fetch drives the master side; the queue is the slave.
interface inst_fetch_queue_if;

    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_inst;

    modport master (
        output push_valid,
        output push_inst,
        input  push_ready
    );

    modport slave (
        input  push_valid,
        input  push_inst,
        output push_ready
    );

endinterface

// File: rtl/inst_field_decode.sv
// Slices an instruction word into fields, extends the immediate
// and flags the class; all outputs read zero when the word is invalid.
module inst_field_decode
    import cpu_isa_pkg::*;
#(
    parameter int IMM_W = 32
) (
    input  logic [31:0]      i_inst,
    input  logic             i_valid,
    output logic [5:0]       o_opcode,
    output logic [4:0]       o_ra,
    output logic [4:0]       o_rb,
    output logic [4:0]       o_wr1,
    output logic [4:0]       o_wr2,
    output logic [4:0]       o_shift_amt,
    output logic [5:0]       o_funct,
    output logic [25:0]      o_address,
    output logic [15:0]      o_imm_raw,
    output logic [IMM_W-1:0] o_imm_ext,
    output logic             o_is_rtype,
    output logic             o_is_jump
);

    logic [31:0]      w_inst;
    logic [5:0]       w_op;
    logic [15:0]      w_imm;
    logic             w_is_logic;
    logic             w_is_lui;
    logic [IMM_W-1:0] w_ext;

    assign w_inst = i_valid ? i_inst : 32'h0;
    assign w_op   = w_inst[OPC_LSB +: 6];
    assign w_imm  = w_inst[IMM_LSB +: 16];

    assign w_is_logic = (w_op == OP_ANDI) || (w_op == OP_ORI) ||
                        (w_op == OP_XORI);
    assign w_is_lui   = (w_op == OP_LUI);

    // Logical immediates zero-extend, LUI loads the upper half.
    always_comb begin
        w_ext = '0;
        unique case (1'b1)
            w_is_logic: w_ext = IMM_W'(w_imm);
            w_is_lui:   w_ext = IMM_W'({w_imm, 16'h0000});
            default:    w_ext = IMM_W'($signed(w_imm));
        endcase
    end

    assign o_opcode    = w_op;
    assign o_ra        = w_inst[RA_LSB +: 5];
    assign o_rb        = w_inst[RB_LSB +: 5];
    assign o_wr1       = w_inst[WR1_LSB +: 5];
    assign o_wr2       = w_inst[WR2_LSB +: 5];
    assign o_shift_amt = w_inst[SHAMT_LSB +: 5];
    assign o_funct     = w_inst[FUNCT_LSB +: 6];
    assign o_address   = w_inst[ADDR_LSB +: 26];
    assign o_imm_raw   = w_imm;
    assign o_imm_ext   = i_valid ? w_ext : '0;
    assign o_is_rtype  = i_valid && (w_op == OP_RTYPE);
    assign o_is_jump   = i_valid && ((w_op == OP_J) || (w_op == OP_JAL));

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction FIFO between memory and control; lets fetch run ahead
// of execute and presents the decoded head instruction.
module inst_fetch_queue
    import cpu_isa_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int IMM_W = 32,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_queue_if.slave  push,
    input  logic               pop,
    input  logic               flush,
    output logic               head_valid,
    output logic [CNT_W-1:0]   count,
    output logic [5:0]         opcode,
    output logic [4:0]         ra,
    output logic [4:0]         rb,
    output logic [4:0]         wr1,
    output logic [4:0]         wr2,
    output logic [4:0]         shift_amt,
    output logic [5:0]         funct,
    output logic [25:0]        address,
    output logic [15:0]        imm_raw,
    output logic [IMM_W-1:0]   imm_ext,
    output logic               is_rtype,
    output logic               is_jump
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = push.push_valid && !w_full;
    assign w_pop   = pop && !w_empty;

    assign push.push_ready = !w_full;
    assign head_valid      = !w_empty;
    assign count           = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage needs no reset; empty entries are masked by head_valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push)
            r_mem[r_wr_ptr] <= push.push_inst;
    end

    inst_field_decode #(
        .IMM_W (IMM_W)
    ) u_dec (
        .i_inst      (r_mem[r_rd_ptr]),
        .i_valid     (head_valid),
        .o_opcode    (opcode),
        .o_ra        (ra),
        .o_rb        (rb),
        .o_wr1       (wr1),
        .o_wr2       (wr2),
        .o_shift_amt (shift_amt),
        .o_funct     (funct),
        .o_address   (address),
        .o_imm_raw   (imm_raw),
        .o_imm_ext   (imm_ext),
        .o_is_rtype  (is_rtype),
        .o_is_jump   (is_jump)
    );

endmodule
